// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers.
// Ports: clk, reset (async high), MDUOp/Start/RdSel/SrcA/SrcB in; MDUOut, Busy, Stall out.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        RdSel,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] MDUOut,
  output logic        Busy,
  output logic        Stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [31:0]   hi, lo;
  logic [31:0]   a_q, b_q;
  logic [3:0]    op_q;
  logic [CW-1:0] cnt;

  logic is_mul, is_div, is_long;

  assign is_mul  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div  = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  assign is_long = Start & (is_mul | is_div);

  assign MDUOut = RdSel ? hi : lo;
  assign Stall  = Busy | is_long;

  logic [63:0] prod_s, prod_u;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide on magnitudes so MIN/-1 wraps cleanly to MIN.
  logic        a_neg, b_neg, dz;
  logic [31:0] ua, ub, ubd, bd;
  logic [31:0] uq, ur, sq, sr;
  logic [31:0] dq, dr;

  assign a_neg = a_q[31];
  assign b_neg = b_q[31];
  assign dz    = (b_q == 32'd0);
  assign ua    = a_neg ? (32'd0 - a_q) : a_q;
  assign ub    = b_neg ? (32'd0 - b_q) : b_q;
  assign ubd   = dz ? 32'd1 : ub;
  assign bd    = dz ? 32'd1 : b_q;
  assign uq    = ua / ubd;
  assign ur    = ua % ubd;
  assign sq    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign sr    = a_neg ? (32'd0 - ur) : ur;
  assign dq    = a_q / bd;
  assign dr    = a_q % bd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 4'd0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_long) begin
            a_q   <= SrcA;
            b_q   <= SrcB;
            op_q  <= MDUOp;
            cnt   <= is_mul ? CW'(MULT_CYCLES)
                            : CW'(DIV_CYCLES);
            Busy  <= 1'b1;
            state <= RUN;
          end else if (Start && MDUOp == OP_MTHI) begin
            hi <= SrcA;
          end else if (Start && MDUOp == OP_MTLO) begin
            lo <= SrcA;
          end
        end
        RUN: begin
          if (cnt != CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            unique case (1'b1)
              (op_q == OP_MULT): begin
                hi <= prod_s[63:32];
                lo <= prod_s[31:0];
              end
              (op_q == OP_MULTU): begin
                hi <= prod_u[63:32];
                lo <= prod_u[31:0];
              end
              (op_q == OP_DIV && !dz): begin
                hi <= sr;
                lo <= sq;
              end
              (op_q == OP_DIVU && !dz): begin
                hi <= dr;
                lo <= dq;
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
